aes_round_sequencer: RTL and testbench

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_round_sequencer.sv | 154 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Steps one 128-bit AES block through NR passes of an external, shared round
// datapath. The sequencer does the initial AddRoundKey itself, launches each
// round with a one-cycle rnd_start pulse, waits ROUND_LAT cycles and captures
// the round result. The finished ciphertext is held until out_ready accepts it.
// Round keys come from an external store addressed by rk_idx, which answers
// in the same cycle.
// Optional feature: define AES_SEQ_ABORT_EN to add an 'abort' input that
// returns the sequencer to IDLE from any busy state.
module aes_round_sequencer #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_SEQ_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         rnd_start,
    output logic [127:0] rnd_data_o,
    output logic [127:0] rnd_key_o,
    output logic         rnd_last,
    input  logic [127:0] rnd_data_i,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [3:0] LAT_LOAD   = 4'(ROUND_LAT);

    logic [1:0]   fsm_q,   fsm_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   cnt_q,   cnt_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q,   key_d;

    // Next-state logic: accept, launch, wait for the datapath, hand off
    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        key_d   = key_q;
        case (fsm_q)
            ST_IDLE: begin
                // rk_idx is 0 here, so rk_data is the whitening key
                if (in_valid) begin
                    state_d = in_data ^ rk_data;
                    round_d = 4'd1;
                    fsm_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Keep the key locally so rnd_key_o stays put during WAIT
                // even if the key store output wanders
                cnt_d = LAT_LOAD;
                key_d = rk_data;
                fsm_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = rnd_data_i;
                    if (round_q == LAST_ROUND) begin
                        fsm_d = ST_DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                        fsm_d   = ST_ISSUE;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    fsm_d   = ST_IDLE;
                    round_d = 4'd0;
                end
            end
        endcase
`ifdef AES_SEQ_ABORT_EN
        // Abort wins over everything, including a DONE handshake
        if (abort && (fsm_q != ST_IDLE)) begin
            fsm_d   = ST_IDLE;
            round_d = 4'd0;
            cnt_d   = 4'd0;
        end
`endif
    end

    // State registers; reset drops any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            round_q <= 4'd0;
            cnt_q   <= 4'd0;
            state_q <= 128'd0;
            key_q   <= 128'd0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    // Output decode; everything outside the active phase is forced to zero
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 128'd0;
        rk_idx     = 4'd0;
        rnd_start  = 1'b0;
        rnd_data_o = 128'd0;
        rnd_key_o  = 128'd0;
        rnd_last   = 1'b0;
        busy       = (fsm_q != ST_IDLE);
        case (fsm_q)
            ST_IDLE: begin
                // in_ready must also read 0 while reset is still asserted
                in_ready = ~rst;
            end
            ST_ISSUE: begin
                rnd_start  = 1'b1;
                rk_idx     = round_q;
                rnd_data_o = state_q;
                rnd_key_o  = rk_data;
                rnd_last   = (round_q == LAST_ROUND);
            end
            ST_WAIT: begin
                rk_idx     = round_q;
                rnd_data_o = state_q;
                rnd_key_o  = key_q;
                rnd_last   = (round_q == LAST_ROUND);
            end
            default: begin
                out_valid = 1'b1;
                out_data  = state_q;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer
// Three sequencer instances (ROUND_LAT = 3, 1, 7) share one behavioural AES
// environment: a key store holding the expanded schedule and a round datapath
// model that returns the round result exactly ROUND_LAT cycles after
// rnd_start (random garbage at all other times). Expected ciphertexts come
// from a block-level AES-128 reference built on an S-box derived from GF(2^8)
// inversion. Abort coverage is compiled in with AES_SEQ_ABORT_EN.
module tb_aes_round_sequencer;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst;
    logic         iv[3], ir[3], ov[3], ordy[3], rs[3], rl[3], bsy[3], ab[3];
    logic [127:0] idat[3], odat[3], rkd[3], rdo[3], rko[3], rdi[3];
    logic [3:0]   rkidx[3];

    logic [127:0] rk_sched[11];
    logic [7:0]   sbox[256];

    // datapath model state and observation logs
    int           cnt_m[3];
    logic [127:0] res_m[3], hd[3], hk[3];
    logic [3:0]   hi[3];
    logic         hl[3];
    int           n_start[3], hold_bad[3], xfer[3], acc[3];
    logic [3:0]   rk_log[3][64];
    logic         last_log[3][64];

    int total;
    int bad;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int L = (gi == 0) ? 3 : ((gi == 1) ? 1 : 7);
            aes_round_sequencer #(.NR(10), .ROUND_LAT(L)) u_dut (
                .clk        (clk),
                .rst        (rst),
`ifdef AES_SEQ_ABORT_EN
                .abort      (ab[gi]),
`endif
                .in_valid   (iv[gi]),
                .in_ready   (ir[gi]),
                .in_data    (idat[gi]),
                .out_valid  (ov[gi]),
                .out_ready  (ordy[gi]),
                .out_data   (odat[gi]),
                .rk_idx     (rkidx[gi]),
                .rk_data    (rkd[gi]),
                .rnd_start  (rs[gi]),
                .rnd_data_o (rdo[gi]),
                .rnd_key_o  (rko[gi]),
                .rnd_last   (rl[gi]),
                .rnd_data_i (rdi[gi]),
                .busy       (bsy[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b[16];
        logic [7:0]   t[16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int n = 0; n < 16; n++) b[n] = sbox[s[127-8*n -: 8]];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[w+4*c] = b[w + 4*((c+w) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                t[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
        end
        for (int n = 0; n < 16; n++) r[127-8*n -: 8] = t[n];
        return r ^ k;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk_sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] aes_encrypt_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_sched[0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, rk_sched[r], r == 10);
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 3 : ((i == 1) ? 1 : 7);
    endfunction

    // ---------------- environment models ----------------
    // key store: combinational lookup by rk_idx
    always_comb begin
        for (int i = 0; i < 3; i++)
            rkd[i] = (rkidx[i] <= 4'd10) ? rk_sched[rkidx[i]] : 128'd0;
    end

    // shared round datapath: result valid only in the cycle ROUND_LAT after rnd_start
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                cnt_m[i] <= 0;
                rdi[i]   <= rand128();
            end else begin
                if (rs[i]) begin
                    res_m[i] <= aes_round(rdo[i], rko[i], rl[i]);
                    cnt_m[i] <= lat_of(i);
                    hd[i] <= rdo[i]; hk[i] <= rko[i]; hi[i] <= rkidx[i]; hl[i] <= rl[i];
                    rk_log[i][n_start[i] % 64]   <= rkidx[i];
                    last_log[i][n_start[i] % 64] <= rl[i];
                    n_start[i] <= n_start[i] + 1;
                end else if (cnt_m[i] != 0) begin
                    cnt_m[i] <= cnt_m[i] - 1;
                    if (rdo[i] !== hd[i] || rko[i] !== hk[i] || rkidx[i] !== hi[i] || rl[i] !== hl[i])
                        hold_bad[i] <= hold_bad[i] + 1;
                end
                rdi[i] <= (cnt_m[i] == 1 && !rs[i]) ? res_m[i] : rand128();
            end
        end
    end

    // handshake counters
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && ov[i] && ordy[i] && !ab[i]) xfer[i] <= xfer[i] + 1;
            if (!rst && iv[i] && ir[i]) acc[i] <= acc[i] + 1;
        end
    end

    // Offer one block on instance i (caller sits at a negedge); returns at the
    // negedge of the first out_valid cycle with the cycle count from accept.
    task automatic run_block(input int i, input logic [127:0] pt, input logic rdy,
                             output logic [127:0] ct, output int lat);
        int w;
        ordy[i] = rdy;
        idat[i] = pt;
        iv[i]   = 1'b1;
        w = 0;
        while (ir[i] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        iv[i]   = 1'b0;
        idat[i] = rand128();
        lat = 1;
        while (ov[i] !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        ct = odat[i];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({ir[i], ov[i], bsy[i], rs[i], rl[i], rkidx[i], odat[i], rdo[i], rko[i]} !== '0) begin
                bad++;
                $display("FAIL reset_outputs[%0d]: got ready=%b valid=%b busy=%b start=%b idx=%h expected all zero",
                         i, ir[i], ov[i], bsy[i], rs[i], rkidx[i]);
            end
        end
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ir[i] !== 1'b1 || bsy[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_release[%0d]: got in_ready=%b busy=%b expected 1 0", i, ir[i], bsy[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_fips();
        logic [127:0] ct;
        int lat, base, hb, x0;
        load_key(FIPS_KEY);
        base = n_start[0]; hb = hold_bad[0]; x0 = xfer[0];
        total++;
        if (rkidx[0] !== 4'd0) begin
            bad++;
            $display("FAIL fips_idle_rk_idx: got %0d expected 0", rkidx[0]);
        end
        run_block(0, FIPS_PT, 1'b1, ct, lat);
        total++;
        if (ct !== FIPS_CT) begin
            bad++;
            $display("FAIL fips_ct: got %h expected %h", ct, FIPS_CT);
        end
        total++;
        if (lat !== 41) begin
            bad++;
            $display("FAIL fips_latency: got %0d expected 41", lat);
        end
        total++;
        if (n_start[0] - base !== 10) begin
            bad++;
            $display("FAIL fips_start_pulses: got %0d expected 10", n_start[0] - base);
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (rk_log[0][(base+k) % 64] !== 4'(k+1) || last_log[0][(base+k) % 64] !== (k == 9)) begin
                bad++;
                $display("FAIL fips_round%0d: got rk_idx=%0d last=%b expected %0d %b",
                         k+1, rk_log[0][(base+k) % 64], last_log[0][(base+k) % 64], k+1, k == 9);
            end
        end
        total++;
        if (hold_bad[0] !== hb) begin
            bad++;
            $display("FAIL fips_wait_hold: got %0d unstable cycles expected 0", hold_bad[0] - hb);
        end
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || xfer[0] - x0 !== 1) begin
            bad++;
            $display("FAIL fips_handoff: got valid=%b ready=%b xfers=%0d expected 0 1 1",
                     ov[0], ir[0], xfer[0] - x0);
        end
    endtask

    task automatic test_random();
        logic [127:0] key, pt, ct, exp;
        int lat, hb;
        for (int n = 0; n < 4; n++) begin
            key = rand128(); pt = rand128();
            load_key(key);
            exp = aes_encrypt_ref(pt);
            hb = hold_bad[0];
            run_block(0, pt, 1'b1, ct, lat);
            total++;
            if (ct !== exp || lat !== 41 || hold_bad[0] !== hb) begin
                bad++;
                $display("FAIL random%0d: got ct=%h lat=%0d expected ct=%h lat=41", n, ct, lat, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, ct, exp;
        int lat, x0, a0;
        load_key(rand128());
        pt = rand128();
        exp = aes_encrypt_ref(pt);
        run_block(0, pt, 1'b0, ct, lat);
        x0 = xfer[0]; a0 = acc[0];
        iv[0] = 1'b1; idat[0] = rand128();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (ov[0] !== 1'b1 || odat[0] !== exp || ir[0] !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_hold%0d: got valid=%b ready=%b data=%h expected 1 0 %h",
                         c, ov[0], ir[0], odat[0], exp);
            end
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (ov[0] !== 1'b0 || xfer[0] - x0 !== 1 || acc[0] - a0 !== 0) begin
            bad++;
            $display("FAIL backpressure_release: got valid=%b xfers=%0d accepts=%0d expected 0 1 0",
                     ov[0], xfer[0] - x0, acc[0] - a0);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct;
        int lat, w;
        load_key(FIPS_KEY);
        idat[0] = FIPS_PT; iv[0] = 1'b1; ordy[0] = 1'b1;
        w = 0;
        while (ir[0] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            iv[0] = 1'b0;
        end
        total++;
        if (bsy[0] !== 1'b1 || rkidx[0] !== 4'd5 || rs[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_position: got busy=%b rk_idx=%0d start=%b expected 1 5 0",
                     bsy[0], rkidx[0], rs[0]);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ir[0], ov[0], bsy[0], rs[0], rl[0], rkidx[0], odat[0], rdo[0], rko[0]} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got busy=%b idx=%0d data_o=%h expected all zero",
                     bsy[0], rkidx[0], rdo[0]);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if (ir[0] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_ready: got %b expected 1", ir[0]);
        end
        @(negedge clk);
        run_block(0, FIPS_PT, 1'b1, ct, lat);
        total++;
        if (ct !== FIPS_CT || lat !== 41) begin
            bad++;
            $display("FAIL reset_mid_next: got ct=%h lat=%0d expected ct=%h lat=41", ct, lat, FIPS_CT);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt1, pt2, e1, e2;
        int lat, w, a0;
        load_key(rand128());
        pt1 = rand128(); pt2 = rand128();
        e1 = aes_encrypt_ref(pt1); e2 = aes_encrypt_ref(pt2);
        a0 = acc[0];
        ordy[0] = 1'b1; idat[0] = pt1; iv[0] = 1'b1;
        w = 0;
        while (ir[0] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        idat[0] = pt2;
        lat = 1;
        while (ov[0] !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (odat[0] !== e1 || lat !== 41 || ir[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: got ct=%h lat=%0d ready=%b expected ct=%h lat=41 ready=0",
                     odat[0], lat, ir[0], e1);
        end
        @(negedge clk);
        total++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_reaccept: got ready=%b valid=%b expected 1 0", ir[0], ov[0]);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 1;
        while (ov[0] !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (odat[0] !== e2 || lat !== 41 || acc[0] - a0 !== 2) begin
            bad++;
            $display("FAIL b2b_second: got ct=%h lat=%0d accepts=%0d expected ct=%h lat=41 accepts=2",
                     odat[0], lat, acc[0] - a0, e2);
        end
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [127:0] ct;
        int lat, base;
        load_key(FIPS_KEY);
        for (int i = 1; i < 3; i++) begin
            base = n_start[i];
            run_block(i, FIPS_PT, 1'b1, ct, lat);
            total++;
            if (ct !== FIPS_CT || lat !== 1 + 10 * (lat_of(i) + 1) || n_start[i] - base !== 10) begin
                bad++;
                $display("FAIL latency_lat%0d: got ct=%h lat=%0d starts=%0d expected ct=%h lat=%0d starts=10",
                         lat_of(i), ct, lat, n_start[i] - base, FIPS_CT, 1 + 10 * (lat_of(i) + 1));
            end
            @(negedge clk);
        end
    endtask

`ifdef AES_SEQ_ABORT_EN
    task automatic test_abort();
        logic [127:0] ct;
        int lat, w, x0;
        load_key(FIPS_KEY);
        x0 = xfer[0];
        idat[0] = rand128(); iv[0] = 1'b1; ordy[0] = 1'b1;
        w = 0;
        while (ir[0] !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            iv[0] = 1'b0;
        end
        total++;
        if (rkidx[0] !== 4'd3 || bsy[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_position: got rk_idx=%0d busy=%b expected 3 1", rkidx[0], bsy[0]);
        end
        ab[0] = 1'b1;
        @(negedge clk);
        ab[0] = 1'b0;
        total++;
        if (bsy[0] !== 1'b0 || ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b valid=%b ready=%b expected 0 0 1", bsy[0], ov[0], ir[0]);
        end
        run_block(0, FIPS_PT, 1'b1, ct, lat);
        total++;
        if (ct !== FIPS_CT || lat !== 41 || xfer[0] - x0 !== 0) begin
            bad++;
            $display("FAIL abort_next: got ct=%h lat=%0d earlier_xfers=%0d expected ct=%h lat=41 0",
                     ct, lat, xfer[0] - x0, FIPS_CT);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        total = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; ab[i] = 1'b0; idat[i] = 128'd0;
        end
        init_sbox();
        load_key(FIPS_KEY);
        test_reset();
        test_fips();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_latency();
`ifdef AES_SEQ_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
